// File: rtl/sopc_pio_in_capture.sv
// Avalon-MM input PIO: synchronises in_port, captures per-bit edges in a sticky
// W1C register and optionally raises a level irq (define SOPC_PIO_IN_IRQ_EN).
module sopc_pio_in_capture #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;

  assign wr_en = chipselect && !write_n;
  assign armed = (arm_cnt == 2'd3);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    raw_edge = '0;
    case (EDGE_TYPE)
      0:       raw_edge = s2 & ~prev;
      1:       raw_edge = ~s2 & prev;
      default: raw_edge = s2 ^ prev;
    endcase
  end

  // Until the pipeline has been refilled after reset, s2/prev disagree only
  // because of their reset values, so those differences must not count.
  assign edge_hit = armed ? raw_edge : '0;
  assign clr      = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, and all of it resets asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      prev     <= '0;
      arm_cnt  <= 2'd0;
      edge_cap <= '0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      prev     <= s2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      edge_cap <= (edge_cap & ~clr) | edge_hit;
    end
  end

`ifdef SOPC_PIO_IN_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && address == ADDR_IRQMASK) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_cap & irq_mask);
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = s2;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      default:      readdata = '0;
    endcase
  end

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_sopc_pio_in_capture.sv
// Bench for sopc_pio_in_capture: three instances (rising, falling, any edge)
// share stimulus and are checked every cycle against a sample-history model.
module tb_sopc_pio_in_capture;

`ifdef SOPC_PIO_IN_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rdata [3];
  logic        irq_v [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sopc_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[0]), .irq(irq_v[0]));

  sopc_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[1]), .irq(irq_v[1]));

  sopc_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[2]), .irq(irq_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: smp[j-1] is the input seen at the j-th edge after reset release.
  // The input sampled at edge j is visible on DATA after edge j+1; an edge
  // between the samples of edges k-3 and k-2 is captured at edge k (k >= 4).
  logic [7:0] smp [$];
  int         cyc;
  logic [7:0] mcap [3];
  logic [7:0] mmask;
  logic [7:0] m_new, m_old, m_clr;
  logic [7:0] m_ev [3];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp.delete();
      cyc   = 0;
      mcap  = '{default: 8'h00};
      mmask = 8'h00;
    end else begin
      cyc++;
      smp.push_back(in_port);
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
      m_ev  = '{default: 8'h00};
      if (cyc >= 4) begin
        m_new   = smp[cyc-3];
        m_old   = smp[cyc-4];
        m_ev[0] = m_new & ~m_old;
        m_ev[1] = ~m_new & m_old;
        m_ev[2] = m_new ^ m_old;
      end
      for (int t = 0; t < 3; t++) mcap[t] = (mcap[t] & ~m_clr) | m_ev[t];
      if (IRQ_EN && chipselect && !write_n && address == 2'd2) mmask = writedata[7:0];
    end
  end

  function automatic logic [31:0] model_rd(input int t);
    logic [31:0] r = 32'h0;
    case (address)
      2'd0: if (cyc >= 2) r = {24'h0, smp[cyc-2]};
      2'd2: r = {24'h0, mmask};
      2'd3: r = {24'h0, mcap[t]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    for (int t = 0; t < 3; t++) begin
      check($sformatf("model_rd%0d_a%0d", t, address), rdata[t], model_rd(t));
      check($sformatf("model_irq%0d", t), {31'h0, irq_v[t]},
            {31'h0, IRQ_EN && (|(mcap[t] & mmask))});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string name, input int t, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rdata[t], exp);
  endtask

  task automatic chk_irq(input string name, input int t, input logic exp);
    #1;
    check(name, {31'h0, irq_v[t]}, {31'h0, exp});
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'hFF;
    #1;
    rd("reset_data", 0, 2'd0, 32'h0);
    rd("reset_cap", 2, 2'd3, 32'h0);
    chk_irq("reset_irq", 0, 1'b0);
    tick(3);
    reset_n = 1'b1;

    // Input held high through release: visible on DATA, never captured.
    tick();
    rd("data_cyc1", 0, 2'd0, 32'h0);
    tick();
    rd("data_cyc2", 0, 2'd0, 32'h0000_00FF);
    tick(20);
    rd("hold_cap_rise", 0, 2'd3, 32'h0);
    rd("hold_cap_any", 2, 2'd3, 32'h0);
    chk_irq("hold_irq", 2, 1'b0);

    // Reserved address reads 0 and ignores writes.
    wr(2'd1, 32'hFFFF_FFFF);
    rd("reserved", 0, 2'd1, 32'h0);

    // Rising edge on bit0 with bit0 masked in.
    wr(2'd2, 32'h01);
    rd("mask_rb", 0, 2'd2, IRQ_EN ? 32'h01 : 32'h0);
    in_port = 8'hFE;
    tick(4);
    rd("fall_cap_fall", 1, 2'd3, 32'h01);
    rd("fall_cap_rise", 0, 2'd3, 32'h0);
    wr(2'd3, 32'hFF);
    in_port = 8'hFF;
    tick();
    tick();
    rd("rise_data_n1", 0, 2'd0, 32'hFF);
    rd("rise_cap_n1", 0, 2'd3, 32'h0);
    chk_irq("rise_irq_n1", 0, 1'b0);
    tick();
    rd("rise_cap_n2", 0, 2'd3, 32'h01);
    chk_irq("rise_irq_n2", 0, IRQ_EN);
    in_port = 8'hFE;
    tick(4);
    rd("no_fall_in_rise", 0, 2'd3, 32'h01);

    // W1C: other bit leaves bit0, own bit clears it.
    wr(2'd3, 32'h02);
    rd("clr_other", 0, 2'd3, 32'h01);
    wr(2'd3, 32'h01);
    rd("clr_own", 0, 2'd3, 32'h0);
    chk_irq("clr_irq", 0, 1'b0);

    // Clear and edge on bit3 in the same cycle: edge wins.
    in_port = 8'hF6;
    tick(4);
    wr(2'd3, 32'hFF);
    in_port = 8'hFE;
    tick(2);
    wr(2'd3, 32'h08);
    rd("clr_vs_edge_rise", 0, 2'd3, 32'h08);
    rd("clr_vs_edge_any", 2, 2'd3, 32'h08);
    rd("clr_vs_edge_fall", 1, 2'd3, 32'h0);

    // Any-edge on bit5, masked out then masked in.
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h00);
    in_port = 8'hDE;
    tick(4);
    rd("any_first", 2, 2'd3, 32'h20);
    chk_irq("any_irq_unmasked", 2, 1'b0);
    in_port = 8'hFE;
    tick(4);
    rd("any_second", 2, 2'd3, 32'h20);
    wr(2'd2, 32'h20);
    chk_irq("any_irq_masked", 2, IRQ_EN);
    wr(2'd2, 32'hFF);
    rd("mask_ff_rb", 2, 2'd2, IRQ_EN ? 32'hFF : 32'h0);

    // Asynchronous reset mid-operation, then re-arm with input held constant.
    in_port = 8'h5A;
    tick(3);
    reset_n = 1'b0;
    rd("midrst_cap", 2, 2'd3, 32'h0);
    rd("midrst_mask", 2, 2'd2, 32'h0);
    rd("midrst_data", 0, 2'd0, 32'h0);
    chk_irq("midrst_irq", 2, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    rd("rearm_cap_any", 2, 2'd3, 32'h0);
    rd("rearm_data", 0, 2'd0, 32'h5A);

    // A short directed run left to the per-cycle model compare.
    wr(2'd2, 32'hC3);
    address = 2'd3;
    in_port = 8'hA5;
    tick(3);
    in_port = 8'h0F;
    tick(3);
    wr(2'd3, 32'h33);
    address = 2'd3;
    in_port = 8'hF0;
    tick(4);
    address = 2'd0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
